// File: rtl/jt6295_ctrl.sv
// jt6295_ctrl: CPU command parser and phrase-table fetcher feeding the 4-channel ADPCM datapath.
// Define JT6295_ROM_TIMEOUT_EN to abandon a phrase fetch after 255 clk without rom_ok.
module jt6295_ctrl #(
    parameter int HOLD_CEN = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen_i,
    input  logic        wrn_i,
    input  logic [7:0]  din_i,
    input  logic [3:0]  busy_i,
    output logic [3:0]  start_o,
    output logic [3:0]  stop_o,
    output logic [17:0] start_addr_o,
    output logic [17:0] stop_addr_o,
    output logic [3:0]  att_o,
    output logic        rom_cs_o,
    output logic [17:0] rom_addr_o,
    input  logic [7:0]  rom_data_i,
    input  logic        rom_ok_i
);
    localparam int HW = $clog2(HOLD_CEN + 1);
    typedef enum logic [2:0] {IDLE, CMD2, READ, ISSUE, HOLD} state_t;
    state_t        state_q, state_d;
    logic          wrn_q, byte_v_q, pend_v_q, pend_v_d, fresh_q, fresh_d, cmd_v, acc;
    logic [7:0]    byte_q, pend_q, pend_d, cmd;
    logic [6:0]    phrase_q, phrase_d;
    logic [3:0]    mask_q, mask_d, attn_q, attn_d, start_q, start_d, stop_q, stop_d, att_q, att_d;
    logic [2:0]    idx_q, idx_d;
    logic [17:0]   sn_q, sn_d, en_q, en_d, sa_q, sa_d, ea_q, ea_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
`ifdef JT6295_ROM_TIMEOUT_EN
    logic [7:0]    tmo_q, tmo_d;
`endif

    // A fresh write wins over the pending byte when both are ready in IDLE
    assign cmd_v = byte_v_q | pend_v_q;
    assign cmd   = byte_v_q ? byte_q : pend_q;
    assign acc   = state_q == READ && !fresh_q && rom_ok_i;

    always_comb begin
        state_d  = state_q;
        phrase_d = phrase_q;
        mask_d   = mask_q;
        attn_d   = attn_q;
        idx_d    = idx_q;
        fresh_d  = 1'b0;
        sn_d     = sn_q;
        en_d     = en_q;
        hcnt_d   = hcnt_q;
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        start_d  = 4'd0;
        stop_d   = 4'd0;
        sa_d     = sa_q;
        ea_d     = ea_q;
        att_d    = att_q;
        case (state_q)
            IDLE: begin
                pend_v_d = 1'b0;
                if (cmd_v && cmd[7]) begin
                    phrase_d = cmd[6:0];
                    state_d  = cmd[6:0] != 7'd0 ? CMD2 : IDLE;
                end else if (cmd_v) begin
                    stop_d = cmd[6:3];
                end
            end
            CMD2: if (byte_v_q) begin
                mask_d  = byte_q[7:4];
                attn_d  = byte_q[3:0];
                idx_d   = 3'd0;
                fresh_d = 1'b1;
                state_d = (byte_q[7:4] & ~busy_i) != 4'd0 ? READ : IDLE;
            end
            READ: if (acc) begin
                // 8-bit shift into 18 bits leaves {b0[1:0], b1, b2} after three bytes
                sn_d    = idx_q < 3'd3 ? {sn_q[9:0], rom_data_i} : sn_q;
                en_d    = idx_q < 3'd3 ? en_q : {en_q[9:0], rom_data_i};
                idx_d   = idx_q + 3'd1;
                fresh_d = 1'b1;
                state_d = idx_q == 3'd5 ? ISSUE : READ;
            end
            ISSUE: begin
                start_d = mask_q & ~busy_i;
                sa_d    = sn_q;
                ea_d    = en_q;
                att_d   = attn_q;
                hcnt_d  = '0;
                state_d = HOLD;
            end
            HOLD: if (cen_i) begin
                hcnt_d  = hcnt_q + 1'b1;
                state_d = hcnt_q == HW'(HOLD_CEN - 1) ? IDLE : HOLD;
            end
            default: state_d = IDLE;
        endcase
        if (byte_v_q && state_q inside {READ, ISSUE, HOLD}) begin
            pend_d   = byte_q;
            pend_v_d = 1'b1;
        end
`ifdef JT6295_ROM_TIMEOUT_EN
        tmo_d = state_q == READ && !acc ? tmo_q + 8'd1 : 8'd0;
        if (state_q == READ && !acc && tmo_q == 8'hff) state_d = IDLE;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wrn_q    <= 1'b1;
            byte_v_q <= 1'b0;
            byte_q   <= 8'd0;
            pend_v_q <= 1'b0;
            pend_q   <= 8'd0;
            fresh_q  <= 1'b0;
            phrase_q <= 7'd0;
            mask_q   <= 4'd0;
            attn_q   <= 4'd0;
            idx_q    <= 3'd0;
            sn_q     <= 18'd0;
            en_q     <= 18'd0;
            hcnt_q   <= '0;
            start_q  <= 4'd0;
            stop_q   <= 4'd0;
            sa_q     <= 18'd0;
            ea_q     <= 18'd0;
            att_q    <= 4'd0;
`ifdef JT6295_ROM_TIMEOUT_EN
            tmo_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            wrn_q    <= wrn_i;
            byte_v_q <= wrn_q & ~wrn_i;
            byte_q   <= din_i;
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
            fresh_q  <= fresh_d;
            phrase_q <= phrase_d;
            mask_q   <= mask_d;
            attn_q   <= attn_d;
            idx_q    <= idx_d;
            sn_q     <= sn_d;
            en_q     <= en_d;
            hcnt_q   <= hcnt_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            sa_q     <= sa_d;
            ea_q     <= ea_d;
            att_q    <= att_d;
`ifdef JT6295_ROM_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign start_o      = start_q;
    assign stop_o       = stop_q;
    assign start_addr_o = sa_q;
    assign stop_addr_o  = ea_q;
    assign att_o        = att_q;
    assign rom_cs_o     = state_q == READ;
    assign rom_addr_o   = {8'd0, phrase_q, idx_q};
endmodule

// File: doc/jt6295_ctrl.md
Name: jt6295_ctrl

Overview:
- Command controller for the 4-channel ADPCM serial datapath.
- Parses the CPU byte stream: two-byte phrase-start commands and one-byte stop commands.
- Fetches the 6-byte start/stop address entry from the phrase table at the bottom of ADPCM ROM.
- Drives start/stop pulses plus start_addr/stop_addr/att into the serial block, sequencing loads so that every channel latches before the next command.

Parameters:
- HOLD_CEN, 4, number of cen pulses that start_addr/stop_addr/att stay stable after a start pulse (one full channel rotation).

Ports:
- clk        in   1   system clock
- rst        in   1   asynchronous reset, active-high
- cen        in   1   channel-slot clock enable, same as the datapath's
- wrn        in   1   CPU write strobe, active-low
- din        in   8   CPU write data
- busy       in   4   per-channel busy from the datapath
- start      out  4   one-clk start pulse per channel
- stop       out  4   one-clk stop pulse per channel
- start_addr out  18  phrase start nibble-pair address
- stop_addr  out  18  phrase stop address
- att        out  4   attenuation for started channels
- rom_cs     out  1   ROM request
- rom_addr   out  18  ROM byte address; bits 17:10 always 0
- rom_data   in   8   ROM data
- rom_ok     in   1   ROM data valid for the current rom_addr

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pending buffer empty.
- Write detect: a write is a clk where wrn was 1 on the previous clk and is 0 now; din is captured on that clk.
- FSM states: IDLE, CMD2, READ, ISSUE, HOLD.
- IDLE, byte with din[7]=1:
  - Capture phrase = din[6:0] and go to CMD2.
  - Phrase 0 means no command: stay in IDLE.
- IDLE, byte with din[7]=0 (stop command):
  - stop = din[6:3] for exactly one clk on the clk after the write.
  - Stay in IDLE.
- CMD2:
  - The next write is always treated as the second byte, regardless of bit 7.
  - Capture mask = din[7:4] and att = din[3:0].
  - If mask & ~busy == 0 (sampled at capture), return to IDLE with no ROM access.
  - Otherwise go to READ with byte index 0.
- READ:
  - rom_cs=1; rom_addr = {8'd0, phrase, idx[2:0]}, idx = 0..5.
  - rom_ok is ignored on the clk rom_addr changes; it is honoured from the next clk on.
  - On an accepted rom_ok:
    - Store rom_data: idx0 -> start[17:16] from data[1:0]; idx1 -> start[15:8]; idx2 -> start[7:0]; idx3..5 -> stop, same layout.
    - Increment idx.
  - After idx5: rom_cs=0, go to ISSUE.
- ISSUE:
  - start_addr/stop_addr/att update on entry.
  - start = mask & ~busy (busy re-sampled here) for one clk.
  - Go to HOLD.
- HOLD:
  - Outputs held stable; count HOLD_CEN cen pulses, then go to IDLE.
  - Output registers change only on entry to ISSUE.
- Latency, rom_ok tied 1: the start pulse is on clk 14 after the clk registering the second byte (1 to enter READ, 2 per byte x6, 1 ISSUE).
- Writes during READ/ISSUE/HOLD go to a 1-entry pending buffer:
  - A later write overwrites it.
  - The buffer is consumed as an IDLE-or-CMD2 byte on the first clk back in IDLE.
  - A write arriving on that same clk takes precedence; the buffer is cleared.
- A start issued to a channel that the mask selects but that is busy is dropped silently; other masked channels still start.
- Stop commands are accepted only in IDLE, directly or via the buffer. This means a stop never collides with start on the same clk.
- rst mid-READ: rom_cs drops immediately (asynchronous), no start is issued, and the buffer is cleared.

Optional Feature:
- JT6295_ROM_TIMEOUT_EN defined:
  - An 8-bit counter runs during READ and is cleared on each accepted rom_ok.
  - If it reaches 255, drop rom_cs, go to IDLE, issue no start, and leave the outputs unchanged.
- Undefined: READ waits indefinitely for rom_ok.

Test Plan:
- Writes 0x81, 0x1A; busy=0; ROM[8..13]=01 23 45 02 00 10; rom_ok=1 -> start=4'b0001 at clk 14; start_addr=0x12345; stop_addr=0x20010; att=0xA; rom_addr 8..13 in order.
- Write 0x78 in IDLE -> stop=4'b1111 for one clk; start stays 0; no rom_cs.
- Writes 0x85, 0xF0 with busy=4'b0101 -> start=4'b1010. Repeat with busy=4'b1111 -> no rom_cs, no start.
- rom_ok low for 3 clks on each byte; write 0x40 during READ -> correct addresses; stop=4'b1000 only after HOLD completes (4 cen pulses after start).
- Writes 0x80, 0x30 -> no ROM access, no start. Then 0x82, 0x20 -> normal start on channel 1.
- Assert rst during idx3 of READ -> rom_cs=0 the same clk, outputs 0, no start after release; JT6295_ROM_TIMEOUT_EN with rom_ok stuck 0 -> rom_cs drops after 255 clk, IDLE.
